// File: rtl/hart_mem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | hart_mem_arbiter                                                         |
// | Round-robin arbiter of per-hart memory requests onto one controller port |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module hart_mem_arbiter #(
  parameter int N_HARTS = 2,
  parameter int HW      = 3
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [N_HARTS-1:0]     w_req,
  input  logic [N_HARTS-1:0]     w_we,
  input  logic [32*N_HARTS-1:0]  w_addr,
  input  logic [32*N_HARTS-1:0]  w_wdata,
  input  logic [3*N_HARTS-1:0]   w_ctrl,
  output logic [N_HARTS-1:0]     w_ack,
  output logic [127:0]           w_rdata,
  output logic [N_HARTS-1:0]     w_hart_stall,
  output logic                   w_mem_req,
  output logic                   w_mem_we,
  output logic [31:0]            w_mem_addr,
  output logic [31:0]            w_mem_wdata,
  output logic [2:0]             w_mem_ctrl,
  input  logic                   w_mem_busy,
  input  logic                   w_mem_done,
  input  logic [127:0]           w_mem_rdata,
  output logic [HW-1:0]          w_grant
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t               r_state;
  logic [HW-1:0]        r_last;
  logic [HW-1:0]        r_grant;
  logic                 r_mem_req;
  logic                 r_mem_we;
  logic [31:0]          r_mem_addr;
  logic [31:0]          r_mem_wdata;
  logic [2:0]           r_mem_ctrl;
  logic [N_HARTS-1:0]   r_ack;
  logic [127:0]         r_rdata;

  // Two priority chains: requesters strictly above r_last first, then wrap to the lowest requester.
  logic [N_HARTS-1:0]   w_above;
  logic [N_HARTS:0]     w_hi_found;
  logic [N_HARTS:0]     w_lo_found;
  logic [HW-1:0]        w_hi_idx   [N_HARTS+1];
  logic [HW-1:0]        w_lo_idx   [N_HARTS+1];
  logic [HW-1:0]        w_pick;
  logic [N_HARTS-1:0]   w_pick_oh;
  logic [N_HARTS-1:0]   w_grant_oh;
  logic [N_HARTS:0]     w_we_acc;
  logic [31:0]          w_addr_acc  [N_HARTS+1];
  logic [31:0]          w_wdata_acc [N_HARTS+1];
  logic [2:0]           w_ctrl_acc  [N_HARTS+1];

  assign w_hi_found[0]  = 1'b0;
  assign w_lo_found[0]  = 1'b0;
  assign w_hi_idx[0]    = '0;
  assign w_lo_idx[0]    = '0;
  assign w_we_acc[0]    = 1'b0;
  assign w_addr_acc[0]  = 32'h0;
  assign w_wdata_acc[0] = 32'h0;
  assign w_ctrl_acc[0]  = 3'h0;

  generate
    for (genvar g = 0; g < N_HARTS; g++) begin : g_hart
      localparam logic [HW-1:0] c_idx = HW'(g);
      assign w_above[g]      = (c_idx > r_last);
      assign w_hi_found[g+1] = w_hi_found[g] | (w_req[g] & w_above[g]);
      assign w_hi_idx[g+1]   = (!w_hi_found[g] && w_req[g] && w_above[g]) ? c_idx : w_hi_idx[g];
      assign w_lo_found[g+1] = w_lo_found[g] | w_req[g];
      assign w_lo_idx[g+1]   = (!w_lo_found[g] && w_req[g]) ? c_idx : w_lo_idx[g];

      assign w_pick_oh[g]    = (w_pick == c_idx);
      assign w_grant_oh[g]   = (r_grant == c_idx);

      // AND-OR select of the winner's request fields; losers are masked out.
      assign w_we_acc[g+1]    = w_we_acc[g] | (w_pick_oh[g] & w_we[g]);
      assign w_addr_acc[g+1]  = w_addr_acc[g]  | (w_pick_oh[g] ? w_addr[32*g +: 32]  : 32'h0);
      assign w_wdata_acc[g+1] = w_wdata_acc[g] | (w_pick_oh[g] ? w_wdata[32*g +: 32] : 32'h0);
      assign w_ctrl_acc[g+1]  = w_ctrl_acc[g]  | (w_pick_oh[g] ? w_ctrl[3*g +: 3]    : 3'h0);
    end
  endgenerate

  assign w_pick = w_hi_found[N_HARTS] ? w_hi_idx[N_HARTS] : w_lo_idx[N_HARTS];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state     <= S_IDLE;
      r_last      <= HW'(N_HARTS - 1);
      r_grant     <= '0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= 32'h0;
      r_mem_wdata <= 32'h0;
      r_mem_ctrl  <= 3'h0;
      r_ack       <= '0;
      r_rdata     <= 128'h0;
    end else begin
      r_ack <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_lo_found[N_HARTS]) begin
            r_grant     <= w_pick;
            r_mem_we    <= w_we_acc[N_HARTS];
            r_mem_addr  <= w_addr_acc[N_HARTS];
            r_mem_wdata <= w_wdata_acc[N_HARTS];
            r_mem_ctrl  <= w_ctrl_acc[N_HARTS];
            r_mem_req   <= 1'b1;
            r_state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (!w_mem_busy) begin
            r_mem_req <= 1'b0;
            r_state   <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (w_mem_done) begin
            r_rdata <= w_mem_rdata;
            r_ack   <= w_grant_oh;
            r_state <= S_RESP;
          end
        end
        S_RESP: begin
          r_last  <= r_grant;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign w_ack        = r_ack;
  assign w_rdata      = r_rdata;
  assign w_hart_stall = w_req & ~r_ack;
  assign w_mem_req    = r_mem_req;
  assign w_mem_we     = r_mem_we;
  assign w_mem_addr   = r_mem_addr;
  assign w_mem_wdata  = r_mem_wdata;
  assign w_mem_ctrl   = r_mem_ctrl;
  assign w_grant      = r_grant;

endmodule
`default_nettype wire

// File: tb/tb_hart_mem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_hart_mem_arbiter                                                      |
// | Randomized bench for hart_mem_arbiter with a round-robin reference model |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_hart_mem_arbiter;
  localparam int N  = 2;
  localparam int HW = 3;

  logic                CLK = 1'b0;
  logic                RST;
  logic [N-1:0]        w_req, w_we, w_ack, w_hart_stall;
  logic [32*N-1:0]     w_addr, w_wdata;
  logic [3*N-1:0]      w_ctrl;
  logic [127:0]        w_rdata, w_mem_rdata;
  logic                w_mem_req, w_mem_we, w_mem_busy, w_mem_done;
  logic [31:0]         w_mem_addr, w_mem_wdata;
  logic [2:0]          w_mem_ctrl;
  logic [HW-1:0]       w_grant;

  int n_vec = 0;
  int n_err = 0;
  int m_last;

  hart_mem_arbiter #(.N_HARTS(N), .HW(HW)) u_dut (
    .CLK(CLK), .RST(RST), .w_req(w_req), .w_we(w_we), .w_addr(w_addr),
    .w_wdata(w_wdata), .w_ctrl(w_ctrl), .w_ack(w_ack), .w_rdata(w_rdata),
    .w_hart_stall(w_hart_stall), .w_mem_req(w_mem_req), .w_mem_we(w_mem_we),
    .w_mem_addr(w_mem_addr), .w_mem_wdata(w_mem_wdata), .w_mem_ctrl(w_mem_ctrl),
    .w_mem_busy(w_mem_busy), .w_mem_done(w_mem_done), .w_mem_rdata(w_mem_rdata),
    .w_grant(w_grant)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Reference: first requester scanning upward from last+1, modulo N.
  function automatic int rr_pick(input logic [N-1:0] req, input int last);
    for (int k = 1; k <= N; k++)
      if (req[(last + k) % N]) return (last + k) % N;
    return -1;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic set_hart(input int h, input logic we, input logic [31:0] a,
                          input logic [31:0] d, input logic [2:0] c);
    w_we[h]             = we;
    w_addr[32*h +: 32]  = a;
    w_wdata[32*h +: 32] = d;
    w_ctrl[3*h +: 3]    = c;
  endtask

  task automatic apply_reset();
    RST = 1'b1; w_req = '0; w_mem_busy = 1'b0; w_mem_done = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    m_last = N - 1;
    step();
  endtask

  // One full transaction starting from IDLE with w_req already driven.
  task automatic do_txn(input int busy, input int dly, input logic [127:0] rd,
                        input bit keep, input bit mutate);
    int h;
    logic we; logic [31:0] a, d; logic [2:0] c;
    logic [N-1:0] oh;
    h  = rr_pick(w_req, m_last);
    we = w_we[h]; a = w_addr[32*h +: 32]; d = w_wdata[32*h +: 32]; c = w_ctrl[3*h +: 3];
    oh = '0; oh[h] = 1'b1;
    step();
    n_vec++;
    if ({w_mem_req, w_mem_we, w_mem_addr, w_mem_wdata, w_mem_ctrl, w_grant} !== {1'b1, we, a, d, c, HW'(h)}) begin
      n_err++;
      $display("FAIL issue: req=%b we=%b addr=%h wdata=%h ctrl=%h grant=%0d, expected req=1 we=%b addr=%h wdata=%h ctrl=%h grant=%0d",
               w_mem_req, w_mem_we, w_mem_addr, w_mem_wdata, w_mem_ctrl, w_grant, we, a, d, c, h);
    end
    if (mutate) set_hart(h, ~we, 32'h0, ~d, ~c);
    for (int b = 0; b < busy; b++) begin
      w_mem_busy = 1'b1;
      step();
      n_vec++;
      if ({w_mem_req, w_mem_we, w_mem_addr, w_mem_wdata, w_mem_ctrl, w_ack} !== {1'b1, we, a, d, c, {N{1'b0}}}) begin
        n_err++;
        $display("FAIL busy_hold[%0d]: req=%b addr=%h wdata=%h ack=%b, expected req=1 addr=%h wdata=%h ack=0",
                 b, w_mem_req, w_mem_addr, w_mem_wdata, w_ack, a, d);
      end
    end
    w_mem_busy = 1'b0;
    step();
    n_vec++;
    if ({w_mem_req, w_mem_addr, w_ack} !== {1'b0, a, {N{1'b0}}}) begin
      n_err++;
      $display("FAIL wait: req=%b addr=%h ack=%b, expected req=0 addr=%h ack=0", w_mem_req, w_mem_addr, w_ack, a);
    end
    for (int k = 0; k < dly; k++) begin
      step();
      n_vec++;
      if (w_ack !== '0) begin
        n_err++;
        $display("FAIL early_ack: ack=%b, expected 0", w_ack);
      end
    end
    w_mem_done = 1'b1; w_mem_rdata = rd;
    step();
    w_mem_done = 1'b0; w_mem_rdata = rand128();
    n_vec++;
    if ({w_ack, w_rdata, w_hart_stall} !== {oh, rd, w_req & ~oh}) begin
      n_err++;
      $display("FAIL resp: ack=%b rdata=%h stall=%b, expected ack=%b rdata=%h stall=%b",
               w_ack, w_rdata, w_hart_stall, oh, rd, w_req & ~oh);
    end
    m_last = h;
    if (!keep) w_req[h] = 1'b0;
    step();
    n_vec++;
    if ({w_ack, w_rdata} !== {{N{1'b0}}, rd}) begin
      n_err++;
      $display("FAIL post_resp: ack=%b rdata=%h, expected ack=0 rdata=%h", w_ack, w_rdata, rd);
    end
  endtask

  task automatic test_reset();
    RST = 1'b0; w_req = '0; w_we = '0; w_addr = '0; w_wdata = '0; w_ctrl = '0;
    w_mem_busy = 1'b0; w_mem_done = 1'b0; w_mem_rdata = '0;
    #2 RST = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    n_vec++;
    if ({w_mem_req, w_mem_we, w_mem_addr, w_mem_wdata, w_mem_ctrl, w_ack, w_rdata, w_grant, w_hart_stall} !== '0) begin
      n_err++;
      $display("FAIL reset: mem_req=%b addr=%h ack=%b rdata=%h grant=%0d stall=%b, expected all 0",
               w_mem_req, w_mem_addr, w_ack, w_rdata, w_grant, w_hart_stall);
    end
    @(negedge CLK);
    RST = 1'b0;
    m_last = N - 1;
    step();
  endtask

  task automatic test_single_read();
    set_hart(0, 1'b0, 32'h8000_1000, 32'h0, 3'b010);
    w_req = 2'b01;
    do_txn(0, 1, 128'h0123456789ABCDEF0123456789ABCDEF, 1'b0, 1'b0);
  endtask

  task automatic test_contention();
    apply_reset();
    set_hart(0, 1'b0, 32'h0000_0100, 32'h1111_1111, 3'b001);
    set_hart(1, 1'b0, 32'h0000_0200, 32'h2222_2222, 3'b100);
    w_req = 2'b11;
    for (int t = 0; t < 4; t++) do_txn(0, 0, rand128(), 1'b1, 1'b0);
    w_req = '0;
    step();
  endtask

  task automatic test_busy_backpressure();
    set_hart(1, 1'b1, 32'h0000_2000, 32'hDEAD_BEEF, 3'b010);
    w_req = 2'b10;
    do_txn(5, 0, rand128(), 1'b0, 1'b0);
  endtask

  task automatic test_spurious_done();
    logic [127:0] held, rd;
    held = w_rdata;
    w_mem_done = 1'b1; w_mem_rdata = rand128();
    step();
    w_mem_done = 1'b0;
    step();
    n_vec++;
    if ({w_ack, w_mem_req, w_rdata} !== {{N{1'b0}}, 1'b0, held}) begin
      n_err++;
      $display("FAIL spurious_idle: ack=%b mem_req=%b rdata=%h, expected ack=0 mem_req=0 rdata=%h", w_ack, w_mem_req, w_rdata, held);
    end
    set_hart(0, 1'b0, 32'h0000_3000, 32'h0, 3'b000);
    w_req = 2'b01;
    step();
    w_mem_busy = 1'b1; w_mem_done = 1'b1; w_mem_rdata = rand128();
    step();
    w_mem_done = 1'b0;
    n_vec++;
    if ({w_ack, w_mem_req, w_rdata} !== {{N{1'b0}}, 1'b1, held}) begin
      n_err++;
      $display("FAIL spurious_issue: ack=%b mem_req=%b rdata=%h, expected ack=0 mem_req=1 rdata=%h", w_ack, w_mem_req, w_rdata, held);
    end
    w_mem_busy = 1'b0;
    step();
    rd = rand128();
    w_mem_done = 1'b1; w_mem_rdata = rd;
    step();
    w_mem_done = 1'b0;
    n_vec++;
    if ({w_ack, w_rdata} !== {2'b01, rd}) begin
      n_err++;
      $display("FAIL spurious_recover: ack=%b rdata=%h, expected ack=01 rdata=%h", w_ack, w_rdata, rd);
    end
    m_last = 0;
    w_req = '0;
    step();
  endtask

  task automatic test_reset_mid_wait();
    set_hart(1, 1'b0, 32'h0000_4000, 32'h0, 3'b011);
    w_req = 2'b10;
    step();
    step();
    n_vec++;
    if (w_mem_req !== 1'b0) begin
      n_err++;
      $display("FAIL rst_pre_wait: mem_req=%b, expected 0", w_mem_req);
    end
    w_req = '0;
    RST = 1'b1;
    #2;
    n_vec++;
    if ({w_mem_req, w_ack, w_grant, w_mem_addr, w_rdata} !== '0) begin
      n_err++;
      $display("FAIL rst_async: mem_req=%b ack=%b grant=%0d addr=%h rdata=%h, expected all 0", w_mem_req, w_ack, w_grant, w_mem_addr, w_rdata);
    end
    @(negedge CLK);
    RST = 1'b0;
    m_last = N - 1;
    step();
    w_mem_done = 1'b1; w_mem_rdata = rand128();
    step();
    w_mem_done = 1'b0;
    step();
    n_vec++;
    if ({w_ack, w_mem_req, w_rdata} !== {{N{1'b0}}, 1'b0, 128'h0}) begin
      n_err++;
      $display("FAIL rst_late_done: ack=%b mem_req=%b rdata=%h, expected ack=0 mem_req=0 rdata=0", w_ack, w_mem_req, w_rdata);
    end
    set_hart(0, 1'b0, 32'h0000_5000, 32'h0, 3'b000);
    w_req = 2'b11;
    do_txn(0, 0, rand128(), 1'b0, 1'b0);
    w_req = '0;
    step();
  endtask

  task automatic test_input_change();
    set_hart(0, 1'b0, 32'h8000_1000, 32'h0, 3'b010);
    w_req = 2'b01;
    do_txn(1, 2, rand128(), 1'b0, 1'b1);
  endtask

  task automatic test_random();
    for (int t = 0; t < 40; t++) begin
      for (int h = 0; h < N; h++)
        if (!w_req[h] && $urandom_range(0, 1) == 1) begin
          set_hart(h, 1'($urandom_range(0, 1)), $urandom, $urandom, 3'($urandom_range(0, 7)));
          w_req[h] = 1'b1;
        end
      if (w_req == '0) begin
        int h;
        h = $urandom_range(0, N - 1);
        set_hart(h, 1'($urandom_range(0, 1)), $urandom, $urandom, 3'($urandom_range(0, 7)));
        w_req[h] = 1'b1;
      end
      do_txn($urandom_range(0, 3), $urandom_range(0, 2), rand128(),
             $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1);
    end
    w_req = '0;
    step();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_contention();
    test_busy_backpressure();
    test_spurious_done();
    test_reset_mid_wait();
    test_input_change();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
